ni_tx_controller: RTL and testbench
===================================

Name: ni_tx_controller

Overview:
Transmit-side controller between the MIPS execute stage and the NoC router port.
- Captures execute-stage results that are flagged for the network, together with a destination ID, into a small FIFO.
- Serialises each word into a 2-flit packet (header, then tail) over a valid/ready handshake to the router.
- Drives a stall back to the pipeline when the FIFO is full.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- DEST_W, 4, destination/source ID width.
- SRC_ID, 0, this node's ID, inserted into every header flit.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- ni_req_E  input  1  execute-stage word is destined for the NoC this cycle.
- NI_in  input  32  payload word from the execute stage.
- ni_dest_E  input  DEST_W  destination node ID for this word.
- stall_E  output  1  FIFO full; the execute stage must hold the word.
- flit_valid  output  1  flit_out is valid.
- flit_ready  input  1  router accepts the flit.
- flit_out  output  34  flit: [33:32] type, [31:0] body.
- tx_busy  output  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset: one clk edge with rst=1 does all of the following:
  - Clears FIFO pointers and count.
  - Sets FSM to IDLE.
  - Forces flit_valid=0, flit_out=0, stall_E=0, tx_busy=0.
- Enqueue: at a clk edge where ni_req_E=1 and the FIFO is not full, push {ni_dest_E, NI_in}.
- stall_E = (count==DEPTH), combinational from the registered count.
  - While full, the push is blocked even if a pop occurs the same cycle; the word is taken on a later cycle.
  - ni_req_E with stall_E=1 is ignored; the upstream stage holds the word.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: flit_valid=0. If count>0 at an edge, go to HEAD.
  - HEAD: flit_valid=1. flit_out = {2'b01, FIFO-head dest, SRC_ID[DEST_W-1:0], zeros}.
    - dest in [31:32-DEST_W], src in the next DEST_W bits down, remaining bits 0.
    - When flit_ready=1 at an edge, go to BODY.
  - BODY: flit_valid=1. flit_out = {2'b10, FIFO-head data}.
    - When flit_ready=1 at an edge, pop the FIFO.
    - Go to HEAD if count>1 before the pop (back-to-back packets, no idle cycle); otherwise go to IDLE.
- flit_out is driven combinationally from state and FIFO head. The FIFO head does not change during a packet, so flit_out is stable while flit_valid=1 and flit_ready=0.
- Latency: a word pushed into an empty FIFO at edge k gives a header valid after edge k+1 and a tail after the header is accepted. Minimum 2 cycles per packet; a sustained stream takes exactly 2 cycles per word.
- flit_ready while in IDLE is ignored.
- The FIFO head is never popped before its tail flit is accepted.
- Reset mid-packet: the packet is dropped and any queued words are discarded. flit_valid=0 from the first edge after rst.
- Type encodings 00 and 11 are never emitted.
- tx_busy = (count!=0) || (state!=IDLE).

Optional Feature:
Macro: NI_TX_STATS_EN.
- When defined, add outputs:
  - pkt_count[31:0]: increments when a tail flit is accepted.
  - stall_count[31:0]: increments each cycle with stall_E=1 and ni_req_E=1.
  - Both are cleared by rst and wrap at 2^32.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Single word. Inputs: NI_in=0xDEADBEEF, ni_dest_E=3, SRC_ID=0, flit_ready=1, pushed at edge k.
   Required: header 0x1_3000_0000 valid after k+1, tail 0x2_DEADBEEF after k+2, FSM IDLE after k+3.
2. Back-to-back. 3 words pushed on consecutive cycles, flit_ready=1.
   Required: 6 consecutive valid flits H,T,H,T,H,T with no idle gap; data in push order.
3. Backpressure. Hold flit_ready=0 for 5 cycles during HEAD, then during BODY.
   Required: flit_out unchanged and flit_valid=1 throughout; no pop; count constant.
4. Full FIFO. DEPTH=4, flit_ready=0, push 5 words.
   Required: stall_E=1 after the 4th push; 5th word not taken. Raise flit_ready and hold ni_req_E: 5th word taken once count<4; all 5 packets delivered in order.
5. Reset mid-packet. Assert rst while in BODY with 2 words queued.
   Required: next cycle flit_valid=0, tx_busy=0, stall_E=0. After rst, a new push yields a correct header with no stale data.
6. Stats (NI_TX_STATS_EN). Run scenario 4.
   Required: pkt_count=5. stall_count equals the number of cycles where both stall_E=1 and ni_req_E=1.

Source files
------------

// File: rtl/ni_tx_controller.sv
// NoC transmit controller: queues execute-stage words and sends each as a header/tail packet.
// Optional NI_TX_STATS_EN macro adds packet and stall counters.
module ni_tx_controller #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DEST_W = 4,
    parameter int unsigned SRC_ID = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ni_req_E,
    input  logic [31:0]       NI_in,
    input  logic [DEST_W-1:0] ni_dest_E,
    output logic              stall_E,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic [33:0]       flit_out,
    output logic              tx_busy
`ifdef NI_TX_STATS_EN
    ,
    output logic [31:0]       pkt_count,
    output logic [31:0]       stall_count
`endif
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = DEST_W + 32;
    localparam int unsigned PAD_W   = 32 - 2 * DEST_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic               full;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic [DEST_W-1:0]  head_dest;
    logic [31:0]        head_data;

`ifdef NI_TX_STATS_EN
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [31:0] stall_count_q, stall_count_d;
`endif

    assign full      = (count_q == CNT_W'(DEPTH));
    assign head      = mem_q[rd_ptr_q];
    assign head_dest = head[ENTRY_W-1:32];
    assign head_data = head[31:0];

    // Next-state: FIFO bookkeeping and packet serialiser
    always_comb begin
        push     = ni_req_E && !full;
        pop      = (state_q == BODY) && flit_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = HEAD;
                end
            end
            HEAD: begin
                if (flit_ready) begin
                    state_d = BODY;
                end
            end
            BODY: begin
                // Chain straight into the next header when more words are queued
                if (flit_ready) begin
                    state_d = (count_q > CNT_W'(1)) ? HEAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef NI_TX_STATS_EN
    always_comb begin
        pkt_count_d   = pkt_count_q;
        stall_count_d = stall_count_q;
        if (pop) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end
        if (full && ni_req_E) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef NI_TX_STATS_EN
            pkt_count_q   <= '0;
            stall_count_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef NI_TX_STATS_EN
            pkt_count_q   <= pkt_count_d;
            stall_count_q <= stall_count_d;
`endif
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= {ni_dest_E, NI_in};
        end
    end

    always_comb begin
        flit_out = '0;
        case (state_q)
            HEAD:    flit_out = {2'b01, head_dest, DEST_W'(SRC_ID), {PAD_W{1'b0}}};
            BODY:    flit_out = {2'b10, head_data};
            default: flit_out = '0;
        endcase
    end

    assign flit_valid = (state_q != IDLE);
    assign stall_E    = full;
    assign tx_busy    = (count_q != '0) || (state_q != IDLE);

`ifdef NI_TX_STATS_EN
    assign pkt_count   = pkt_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_ni_tx_controller.sv
// Scoreboard bench for ni_tx_controller: stimulus queues expected flits, a monitor checks accepted flits.
module tb_ni_tx_controller;

    logic        clk;
    logic        rst;
    logic        ni_req_E;
    logic [31:0] NI_in;
    logic [3:0]  ni_dest_E;
    logic        stall_E;
    logic        flit_valid;
    logic        flit_ready;
    logic [33:0] flit_out;
    logic        tx_busy;
`ifdef NI_TX_STATS_EN
    logic [31:0] pkt_count;
    logic [31:0] stall_count;
    int          exp_stall;
`endif

    int checks;
    int errors;
    int cyc;
    logic [33:0] exp_q[$];
    int          acc_log[$];
    logic        prev_hold;
    logic [33:0] prev_flit;

    ni_tx_controller #(.DEPTH(4), .DEST_W(4), .SRC_ID(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .ni_req_E   (ni_req_E),
        .NI_in      (NI_in),
        .ni_dest_E  (ni_dest_E),
        .stall_E    (stall_E),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .flit_out   (flit_out),
        .tx_busy    (tx_busy)
`ifdef NI_TX_STATS_EN
        ,
        .pkt_count  (pkt_count),
        .stall_count(stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [33:0] hdr(input logic [3:0] dest);
        return {2'b01, dest, 4'h0, 24'h0};
    endfunction

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every accepted flit is compared against the scoreboard head
    always @(negedge clk) begin
        cyc++;
        if (!rst && flit_valid) begin
            checks++;
            if (flit_out[33:32] != 2'b01 && flit_out[33:32] != 2'b10) begin
                errors++;
                $display("FAIL flit_type: got %b expected 01 or 10", flit_out[33:32]);
            end
            if (prev_hold) begin
                checks++;
                if (flit_out !== prev_flit) begin
                    errors++;
                    $display("FAIL hold_stable: got %h expected %h", flit_out, prev_flit);
                end
            end
            if (flit_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_flit: got %h expected none", flit_out);
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    if (flit_out !== e) begin
                        errors++;
                        $display("FAIL flit_data: got %h expected %h", flit_out, e);
                    end
                end
                acc_log.push_back(cyc);
            end
        end
        prev_hold = !rst && flit_valid && !flit_ready;
        prev_flit = flit_out;
`ifdef NI_TX_STATS_EN
        if (rst) exp_stall = 0;
        else if (stall_E && ni_req_E) exp_stall++;
`endif
    end

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] dest);
        int n;
        n = 0;
        ni_req_E  = 1'b1;
        NI_in     = d;
        ni_dest_E = dest;
        while (stall_E && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got stall_E=1 expected release");
        end else begin
            exp_q.push_back(hdr(dest));
            exp_q.push_back({2'b10, d});
        end
        @(posedge clk); #1;
        ni_req_E = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        prev_hold = 1'b0; prev_flit = '0;
`ifdef NI_TX_STATS_EN
        exp_stall = 0;
`endif
        ni_req_E = 1'b0; NI_in = '0; ni_dest_E = '0; flit_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        chk("reset_valid", 34'(flit_valid), 34'(1'b0));
        chk("reset_flit", flit_out, 34'h0);
        chk("reset_stall", 34'(stall_E), 34'(1'b0));
        chk("reset_busy", 34'(tx_busy), 34'(1'b0));

        // Single word
        flit_ready = 1'b1;
        push(32'hDEADBEEF, 4'd3);
        chk("s1_valid_k", 34'(flit_valid), 34'(1'b0));
        chk("s1_busy_k", 34'(tx_busy), 34'(1'b1));
        @(posedge clk); #1;
        chk("s1_head", flit_out, 34'h1_3000_0000);
        @(posedge clk); #1;
        chk("s1_tail", flit_out, 34'h2_DEADBEEF);
        @(posedge clk); #1;
        chk("s1_idle_valid", 34'(flit_valid), 34'(1'b0));
        chk("s1_idle_busy", 34'(tx_busy), 34'(1'b0));

        // Back-to-back stream
        acc_log.delete();
        push(32'h1111_1111, 4'd1);
        push(32'h2222_2222, 4'd2);
        push(32'h3333_3333, 4'd4);
        drain();
        chk("s2_flit_count", 34'(acc_log.size()), 34'd6);
        if (acc_log.size() == 6)
            chk("s2_no_gap", 34'(acc_log[5] - acc_log[0]), 34'd5);

        // Backpressure in HEAD then BODY
        flit_ready = 1'b0;
        push(32'hCAFE_F00D, 4'd9);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("s3_head_valid", 34'(flit_valid), 34'(1'b1));
            chk("s3_head_hold", flit_out, 34'h1_9000_0000);
            @(posedge clk); #1;
        end
        flit_ready = 1'b1;
        @(posedge clk); #1;
        flit_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("s3_body_valid", 34'(flit_valid), 34'(1'b1));
            chk("s3_body_hold", flit_out, 34'h2_CAFEF00D);
            chk("s3_busy", 34'(tx_busy), 34'(1'b1));
            @(posedge clk); #1;
        end
        flit_ready = 1'b1;
        drain();

        // Full FIFO with held request
        do_reset();
        flit_ready = 1'b0;
        push(32'hA000_0001, 4'd1);
        push(32'hA000_0002, 4'd2);
        push(32'hA000_0003, 4'd3);
        chk("s4_not_full_3", 34'(stall_E), 34'(1'b0));
        push(32'hA000_0004, 4'd4);
        chk("s4_full", 34'(stall_E), 34'(1'b1));
        ni_req_E = 1'b1; NI_in = 32'hA000_0005; ni_dest_E = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("s4_still_full", 34'(stall_E), 34'(1'b1));
        end
        flit_ready = 1'b1;
        push(32'hA000_0005, 4'd5);
        drain();
`ifdef NI_TX_STATS_EN
        chk("s6_pkt_count", 34'(pkt_count), 34'd5);
        chk("s6_stall_count", 34'(stall_count), 34'(exp_stall));
`endif

        // Reset while in BODY with two words queued
        flit_ready = 1'b0;
        push(32'hBBBB_0001, 4'd6);
        push(32'hBBBB_0002, 4'd7);
        flit_ready = 1'b1;
        @(posedge clk); #1;
        flit_ready = 1'b0;
        chk("s5_in_body", flit_out, 34'h2_BBBB0001);
        do_reset();
        chk("s5_valid", 34'(flit_valid), 34'(1'b0));
        chk("s5_busy", 34'(tx_busy), 34'(1'b0));
        chk("s5_stall", 34'(stall_E), 34'(1'b0));
        flit_ready = 1'b1;
        push(32'hC0DE_0001, 4'd8);
        chk("s5_new_head", flit_out, 34'h0);
        @(posedge clk); #1;
        chk("s5_new_head", flit_out, 34'h1_8000_0000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
